ring_plotter: RTL and testbench



---
 rtl/ring_plotter.sv | 233 +++++++++++++++++++++++
 tb/tb_ring_plotter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_plotter.sv
// ring_plotter
// Keeps two concentric rings on a 160x120 framebuffer in step with the two
// animated radii coming from the radius-tracking stage. When a target radius
// differs from the one on screen, the old ring is erased in the background
// colour and the new one is drawn with the midpoint circle algorithm. Pixels
// are written one per cycle to the VGA adapter's write port.
//
// Ports:
//   clock   system clock
//   reset   synchronous, active-high
//   r1      target radius of ring 1 (high note)
//   r2      target radius of ring 2 (low note)
//   x, y    pixel coordinate (registered)
//   colour  pixel colour (registered)
//   plot    write strobe, qualifies x/y/colour in the same cycle
//   busy    high whenever a job is in progress
module ring_plotter #(
  parameter int         CX       = 80,
  parameter int         CY       = 60,
  parameter logic [2:0] COL_HIGH = 3'b010,
  parameter logic [2:0] COL_LOW  = 3'b100,
  parameter logic [2:0] COL_BG   = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] r1,
  input  logic [6:0] r2,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, INIT, PLOT, STEP} state_t;

  localparam logic signed [8:0] CX_S = 9'(CX);
  localparam logic signed [8:0] CY_S = 9'(CY);

  state_t            state_reg, state_next;
  logic              ring_reg, ring_next;        // 0: ring 1, 1: ring 2
  logic              erase_reg, erase_next;      // current pass is the erase pass
  logic [6:0]        target_reg, target_next;    // radius latched at job selection
  logic [6:0]        rad_reg, rad_next;          // radius of the current pass
  logic [2:0]        col_reg, col_next;          // colour of the current pass
  logic [7:0]        px_reg, px_next;
  logic [7:0]        py_reg, py_next;
  logic signed [8:0] d_reg, d_next;
  logic [2:0]        k_reg, k_next;              // octant index within PLOT
  logic [6:0]        drawn_r1_reg, drawn_r1_next;
  logic [6:0]        drawn_r2_reg, drawn_r2_next;
  logic              redraw1_reg, redraw1_next;
  logic              redraw2_reg, redraw2_next;
  logic [7:0]        x_reg, x_next;
  logic [6:0]        y_reg, y_next;
  logic [2:0]        colour_reg, colour_next;
  logic              plot_reg, plot_next;

  // Job selection: ring 1 has priority over ring 2.
  logic       want1, want2, sel_erase;
  logic [6:0] sel_target, sel_drawn, oth_drawn;

  always_comb begin
    want1      = (r1 != drawn_r1_reg) || redraw1_reg;
    want2      = (r2 != drawn_r2_reg) || redraw2_reg;
    sel_target = want1 ? r1 : r2;
    sel_drawn  = want1 ? drawn_r1_reg : drawn_r2_reg;
    oth_drawn  = want1 ? drawn_r2_reg : drawn_r1_reg;
    // A ring that is only flagged for redraw keeps its pixels; skip the erase.
    sel_erase  = (sel_drawn != 7'd0) && (sel_target != sel_drawn);
  end

  // Octant point: k[2] swaps px/py, k[0] negates the x offset, k[1] the y offset.
  logic [7:0]        off_x, off_y;
  logic signed [8:0] sx, sy;
  logic              on_screen;

  always_comb begin
    off_x     = k_reg[2] ? py_reg : px_reg;
    off_y     = k_reg[2] ? px_reg : py_reg;
    sx        = k_reg[0] ? (CX_S - signed'({1'b0, off_x})) : (CX_S + signed'({1'b0, off_x}));
    sy        = k_reg[1] ? (CY_S - signed'({1'b0, off_y})) : (CY_S + signed'({1'b0, off_y}));
    on_screen = (sx >= 9'sd0) && (sx <= 9'sd159) && (sy >= 9'sd0) && (sy <= 9'sd119);
  end

  // Midpoint decision update for the STEP state.
  logic signed [8:0] px_s, py_s, d_step;
  logic [7:0]        px_step, py_step;

  always_comb begin
    px_s = signed'({1'b0, px_reg});
    py_s = signed'({1'b0, py_reg});
    if (d_reg < 9'sd0) begin
      d_step  = d_reg + (px_s <<< 1) + 9'sd3;
      py_step = py_reg;
    end else begin
      d_step  = d_reg + ((px_s - py_s) <<< 1) + 9'sd5;
      py_step = py_reg - 8'd1;
    end
    px_step = px_reg + 8'd1;
  end

  logic pass_done;

  always_comb begin
    state_next    = state_reg;
    ring_next     = ring_reg;
    erase_next    = erase_reg;
    target_next   = target_reg;
    rad_next      = rad_reg;
    col_next      = col_reg;
    px_next       = px_reg;
    py_next       = py_reg;
    d_next        = d_reg;
    k_next        = k_reg;
    drawn_r1_next = drawn_r1_reg;
    drawn_r2_next = drawn_r2_reg;
    redraw1_next  = redraw1_reg;
    redraw2_next  = redraw2_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    colour_next   = colour_reg;
    plot_next     = 1'b0;
    pass_done     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (want1 || want2) begin
          ring_next   = !want1;
          target_next = sel_target;
          erase_next  = sel_erase;
          rad_next    = sel_erase ? sel_drawn : sel_target;
          col_next    = sel_erase ? COL_BG : (want1 ? COL_HIGH : COL_LOW);
          if (want1) redraw1_next = 1'b0;
          else       redraw2_next = 1'b0;
          // Erasing over the other ring punches holes in it; flag it for repaint.
          if (sel_erase && (sel_drawn == oth_drawn)) begin
            if (want1) redraw2_next = 1'b1;
            else       redraw1_next = 1'b1;
          end
          state_next = INIT;
        end
      end
      INIT: begin
        px_next = 8'd0;
        py_next = {1'b0, rad_reg};
        d_next  = 9'sd1 - signed'({2'b00, rad_reg});
        k_next  = 3'd0;
        if (rad_reg == 7'd0) pass_done = 1'b1;
        else                 state_next = PLOT;
      end
      PLOT: begin
        x_next      = sx[7:0];
        y_next      = sy[6:0];
        colour_next = col_reg;
        plot_next   = on_screen;
        k_next      = k_reg + 3'd1;
        if (k_reg == 3'd7) state_next = STEP;
      end
      STEP: begin
        d_next  = d_step;
        py_next = py_step;
        px_next = px_step;
        k_next  = 3'd0;
        if (px_step <= py_step) state_next = PLOT;
        else                    pass_done  = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (pass_done) begin
      if (erase_reg) begin
        erase_next = 1'b0;
        rad_next   = target_reg;
        col_next   = ring_reg ? COL_LOW : COL_HIGH;
        state_next = INIT;
      end else begin
        if (ring_reg) drawn_r2_next = target_reg;
        else          drawn_r1_next = target_reg;
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      ring_reg     <= 1'b0;
      erase_reg    <= 1'b0;
      target_reg   <= 7'd0;
      rad_reg      <= 7'd0;
      col_reg      <= 3'd0;
      px_reg       <= 8'd0;
      py_reg       <= 8'd0;
      d_reg        <= 9'sd0;
      k_reg        <= 3'd0;
      drawn_r1_reg <= 7'd0;
      drawn_r2_reg <= 7'd0;
      redraw1_reg  <= 1'b0;
      redraw2_reg  <= 1'b0;
      x_reg        <= 8'd0;
      y_reg        <= 7'd0;
      colour_reg   <= 3'd0;
      plot_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ring_reg     <= ring_next;
      erase_reg    <= erase_next;
      target_reg   <= target_next;
      rad_reg      <= rad_next;
      col_reg      <= col_next;
      px_reg       <= px_next;
      py_reg       <= py_next;
      d_reg        <= d_next;
      k_reg        <= k_next;
      drawn_r1_reg <= drawn_r1_next;
      drawn_r2_reg <= drawn_r2_next;
      redraw1_reg  <= redraw1_next;
      redraw2_reg  <= redraw2_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      colour_reg   <= colour_next;
      plot_reg     <= plot_next;
    end
  end

  assign x      = x_reg;
  assign y      = y_reg;
  assign colour = colour_reg;
  assign plot   = plot_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_ring_plotter.sv
// Bench for ring_plotter: a default instance (CY=60) and a clipping instance
// (CY=5). A behavioural model derives the expected pixel stream and busy time
// of every job directly from the ring rules.
module tb_ring_plotter;

  logic       clock = 1'b0;
  logic       reset, reset_c;
  logic [6:0] r1, r2, r1c, r2c;
  logic [7:0] x, xc;
  logic [6:0] y, yc;
  logic [2:0] colour, colourc;
  logic       plot, plotc, busy, busyc;

  always #5 clock = ~clock;

  ring_plotter dut (
    .clock(clock), .reset(reset), .r1(r1), .r2(r2),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  ring_plotter #(.CY(5)) dut_clip (
    .clock(clock), .reset(reset_c), .r1(r1c), .r2(r2c),
    .x(xc), .y(yc), .colour(colourc), .plot(plotc), .busy(busyc)
  );

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  pix_t act_q[$], actc_q[$], exp_q[$], expc_q[$];
  int   busy_cnt = 0, busyc_cnt = 0;
  int   n_tests = 0, n_fail = 0;
  int   m_drawn[2][2];
  int   m_rd[2][2];
  int   p_base, b_base;

  // Monitor: the only writer of the observed streams and busy counters.
  always @(negedge clock) begin
    if (plot)  act_q.push_back(pix_t'({x, y, colour}));
    if (busy)  busy_cnt++;
    if (plotc) actc_q.push_back(pix_t'({xc, yc, colourc}));
    if (busyc) busyc_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One pass of radius r: every octant point per iteration, off-screen ones dropped.
  task automatic model_pass(input int inst, input int r, input logic [2:0] c, inout int cyc);
    int px, py, d, cx, cy, sx, sy;
    int dx[8];
    int dy[8];
    pix_t p;
    cx = 80;
    cy = (inst == 0) ? 60 : 5;
    cyc += 1;
    if (r != 0) begin
      px = 0; py = r; d = 1 - r;
      while (px <= py) begin
        dx = '{px, -px, px, -px, py, -py, py, -py};
        dy = '{py, py, -py, -py, px, px, -px, -px};
        for (int k = 0; k < 8; k++) begin
          sx = cx + dx[k];
          sy = cy + dy[k];
          if (sx >= 0 && sx <= 159 && sy >= 0 && sy <= 119) begin
            p.px = 8'(sx); p.py = 7'(sy); p.pc = c;
            if (inst == 0) exp_q.push_back(p);
            else           expc_q.push_back(p);
          end
        end
        cyc += 9;
        if (d < 0) d += 2 * px + 3;
        else begin
          d += 2 * (px - py) + 5;
          py--;
        end
        px++;
      end
    end
  endtask

  // Run every job the plotter would perform with the targets held constant.
  task automatic model_settle(input int inst, input int t1, input int t2, output int cyc);
    int tgt[2];
    int ring, other, old;
    bit erase;
    tgt[0] = t1; tgt[1] = t2; cyc = 0;
    while (tgt[0] != m_drawn[inst][0] || m_rd[inst][0] != 0 ||
           tgt[1] != m_drawn[inst][1] || m_rd[inst][1] != 0) begin
      ring  = (tgt[0] != m_drawn[inst][0] || m_rd[inst][0] != 0) ? 0 : 1;
      other = 1 - ring;
      old   = m_drawn[inst][ring];
      erase = (old != 0) && (tgt[ring] != old);
      m_rd[inst][ring] = 0;
      if (erase) begin
        if (m_drawn[inst][other] == old) m_rd[inst][other] = 1;
        model_pass(inst, old, 3'b000, cyc);
      end
      model_pass(inst, tgt[ring], (ring == 0) ? 3'b010 : 3'b100, cyc);
      m_drawn[inst][ring] = tgt[ring];
    end
  endtask

  task automatic mark();
    p_base = act_q.size();
    b_base = busy_cnt;
  endtask

  task automatic wait_settled(input string tag);
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 3 && n < 20000) begin
      @(negedge clock);
      n++;
      if (busy || busyc) quiet = 0;
      else               quiet++;
    end
    check_val({tag, "_settled"}, (quiet >= 3) ? 1 : 0, 1);
  endtask

  task automatic compare_stream(input string tag, input int inst, input int exp_cyc,
                                input int pbase, input int bbase);
    int   nact, nexp, nbad;
    pix_t a, e, fa, fe;
    nact = ((inst == 0) ? act_q.size() : actc_q.size()) - pbase;
    nexp = (inst == 0) ? exp_q.size() : expc_q.size();
    check_val({tag, "_plots"}, nact, nexp);
    check_val({tag, "_busy_cycles"}, ((inst == 0) ? busy_cnt : busyc_cnt) - bbase, exp_cyc);
    nbad = 0; fa = '0; fe = '0;
    for (int i = 0; i < nact && i < nexp; i++) begin
      a = (inst == 0) ? act_q[pbase + i] : actc_q[pbase + i];
      e = (inst == 0) ? exp_q[i] : expc_q[i];
      if (a !== e) begin
        if (nbad == 0) begin fa = a; fe = e; end
        nbad++;
      end
    end
    check_val({tag, "_pixels_bad"}, nbad, 0);
    if (nbad != 0)
      $display("  %s first differing pixel: got (%0d,%0d,c=%b), want (%0d,%0d,c=%b)",
               tag, fa.px, fa.py, fa.pc, fe.px, fe.py, fe.pc);
    if (inst == 0) exp_q.delete();
    else           expc_q.delete();
  endtask

  initial begin
    int   cyc, cyc2, lat, n, ord_ok, last_other, first_low, bad_y, pbc, bbc;
    int   tx[8];
    int   ty[8];
    int   nr1, nr2, mode;
    pix_t a;

    foreach (m_drawn[i, j]) begin m_drawn[i][j] = 0; m_rd[i][j] = 0; end
    reset = 1'b1; reset_c = 1'b1;
    r1 = 7'd0; r2 = 7'd0; r1c = 7'd0; r2c = 7'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0; reset_c = 1'b0;

    // Reset state, then 50 idle cycles with both radii zero.
    mark();
    repeat (50) @(negedge clock);
    check_val("idle_plots", act_q.size() - p_base, 0);
    check_val("idle_busy", busy_cnt - b_base, 0);
    check_val("idle_x", x, 0);
    check_val("idle_y", y, 0);
    check_val("idle_colour", colour, 0);
    $display("[TB] reset/idle: %0d plots", act_q.size() - p_base);

    // r1=1 from reset: latency and the exact eight points.
    mark();
    r1 = 7'd1;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!plot && lat < 20);
    check_val("first_plot_latency", lat, 3);
    wait_settled("r1_1");
    tx = '{80, 80, 80, 80, 81, 79, 81, 79};
    ty = '{61, 61, 59, 59, 60, 60, 60, 60};
    for (int i = 0; i < 8 && p_base + i < act_q.size(); i++) begin
      a = act_q[p_base + i];
      check_val($sformatf("r1_1_pt%0d", i), {a.px, a.py, a.pc}, {8'(tx[i]), 7'(ty[i]), 3'b010});
    end
    model_settle(0, 1, 0, cyc);
    compare_stream("r1_1", 0, cyc, p_base, b_base);
    $display("[TB] r1 0->1: latency %0d, %0d busy cycles", lat, busy_cnt - b_base);

    // r1 1->2: erase then draw.
    mark();
    r1 = 7'd2;
    model_settle(0, 2, 0, cyc);
    wait_settled("r1_2");
    compare_stream("r1_2", 0, cyc, p_base, b_base);
    $display("[TB] r1 1->2: %0d plots", act_q.size() - p_base);

    // Both radii change together: ring 1 job finishes before any ring 2 pixel.
    mark();
    r1 = 7'd4; r2 = 7'd3;
    model_settle(0, 4, 3, cyc);
    wait_settled("both");
    last_other = -1; first_low = -1;
    for (int i = p_base; i < act_q.size(); i++) begin
      if (act_q[i].pc == 3'b100) begin
        if (first_low < 0) first_low = i;
      end else last_other = i;
    end
    ord_ok = (first_low >= 0 && last_other < first_low) ? 1 : 0;
    check_val("ring1_before_ring2", ord_ok, 1);
    compare_stream("both", 0, cyc, p_base, b_base);
    $display("[TB] r1=4,r2=3 together: %0d plots", act_q.size() - p_base);

    // Change r1 to 5 while the radius-3 draw pass is running.
    mark();
    r1 = 7'd3;
    n = 0;
    while (n < 2000) begin
      @(negedge clock);
      n++;
      cyc2 = 0;
      for (int i = p_base; i < act_q.size(); i++) if (act_q[i].pc == 3'b010) cyc2++;
      if (cyc2 >= 5) break;
    end
    check_val("midjob_reached_draw", (cyc2 >= 5) ? 1 : 0, 1);
    r1 = 7'd5;
    model_settle(0, 3, 3, cyc);
    model_settle(0, 5, 3, cyc2);
    wait_settled("midjob");
    compare_stream("midjob", 0, cyc + cyc2, p_base, b_base);
    $display("[TB] r1 4->3 then 5 mid-pass: %0d plots", act_q.size() - p_base);

    // Clipping instance: CY=5, r1=10.
    pbc = actc_q.size(); bbc = busyc_cnt;
    r1c = 7'd10;
    model_settle(1, 10, 0, cyc);
    wait_settled("clip");
    bad_y = 0;
    for (int i = pbc; i < actc_q.size(); i++) if (actc_q[i].py > 7'd119) bad_y++;
    check_val("clip_y_range", bad_y, 0);
    compare_stream("clip", 1, cyc, pbc, bbc);
    $display("[TB] clip CY=5 r=10: %0d plots, %0d busy cycles", actc_q.size() - pbc, busyc_cnt - bbc);

    // Reset while plotting.
    r1 = 7'd60;
    n = 0;
    do begin @(negedge clock); n++; end while (!plot && n < 200);
    check_val("reset_mid_saw_plot", plot, 1);
    reset = 1'b1;
    @(negedge clock);
    check_val("reset_mid_plot", plot, 0);
    check_val("reset_mid_busy", busy, 0);
    check_val("reset_mid_x", x, 0);
    reset = 1'b0;
    m_drawn[0][0] = 0; m_drawn[0][1] = 0; m_rd[0][0] = 0; m_rd[0][1] = 0;
    exp_q.delete();
    mark();
    model_settle(0, 60, 3, cyc);
    wait_settled("after_reset");
    compare_stream("after_reset", 0, cyc, p_base, b_base);
    $display("[TB] reset mid-plot then r1=60: %0d plots", act_q.size() - p_base);

    // Randomized jobs, including equal radii to exercise the repaint rule.
    for (int it = 0; it < 12; it++) begin
      mode = $urandom_range(0, 3);
      nr1 = r1; nr2 = r2;
      case (mode)
        0: begin nr1 = $urandom_range(0, 70); nr2 = $urandom_range(0, 70); end
        1: begin nr1 = $urandom_range(0, 70); nr2 = nr1; end
        2: begin if ($urandom_range(0, 1) == 0) nr1 = $urandom_range(0, 70);
                 else nr2 = $urandom_range(0, 70); end
        default: begin nr2 = r1; nr1 = $urandom_range(0, 70); end
      endcase
      mark();
      r1 = 7'(nr1); r2 = 7'(nr2);
      model_settle(0, nr1, nr2, cyc);
      wait_settled($sformatf("rand%0d", it));
      compare_stream($sformatf("rand%0d", it), 0, cyc, p_base, b_base);
      $display("[TB] rand%0d r1=%0d r2=%0d: %0d plots, %0d busy cycles",
               it, nr1, nr2, act_q.size() - p_base, busy_cnt - b_base);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
